// File: rtl/gpio_cmd_rx_if.sv
// Bundle of GPIO words and datapath handshakes between the processor bridge,
// the command responder and the memory/convolution datapath.
interface gpio_cmd_rx_if #(
  parameter int GPIO_D = 32,
  parameter int DATA_W = 24,
  parameter int RES_W  = 13,
  parameter int LEN_W  = 11
);
  logic [GPIO_D-1:0]   i_gpio_data;
  logic [GPIO_D-1:0]   o_gpio_data;
  logic [3*DATA_W-1:0] o_kernel;
  logic                o_kernel_valid;
  logic [LEN_W-1:0]    o_img_len;
  logic                o_wr_en;
  logic [DATA_W-1:0]   o_wr_data;
  logic                o_load_last;
  logic                i_conv_done;
  logic                o_rd_en;
  logic [RES_W-1:0]    i_rd_data;
  logic                o_led;

  modport slave (
    input  i_gpio_data, i_conv_done, i_rd_data,
    output o_gpio_data, o_kernel, o_kernel_valid, o_img_len, o_wr_en,
           o_wr_data, o_load_last, o_rd_en, o_led
  );

  modport master (
    output i_gpio_data, i_conv_done, i_rd_data,
    input  o_gpio_data, o_kernel, o_kernel_valid, o_img_len, o_wr_en,
           o_wr_data, o_load_last, o_rd_en, o_led
  );
endinterface

// File: rtl/gpio_cmd_rx.sv
// GPIO command responder: synchronizes the processor's valid strobe, decodes
// kernel/length/write/last/readout commands and returns results plus status.
module gpio_cmd_rx #(
  parameter int GPIO_D = 32,
  parameter int DATA_W = 24,
  parameter int RES_W  = 13,
  parameter int LEN_W  = 11
) (
  input  logic         i_clock,
  input  logic         i_reset,
  gpio_cmd_rx_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, CONV, READ} state_t;

  localparam logic [2:0] CMD_KERNEL = 3'b000;
  localparam logic [2:0] CMD_LEN    = 3'b001;
  localparam logic [2:0] CMD_WRITE  = 3'b010;
  localparam logic [2:0] CMD_READ   = 3'b011;
  localparam logic [2:0] CMD_LAST   = 3'b100;

  logic [2:0]        cmd_ctrl;
  logic [DATA_W-1:0] cmd_data;
  logic              unused_bits;

  assign cmd_ctrl    = bus.i_gpio_data[GPIO_D-1 -: 3];
  assign cmd_data    = bus.i_gpio_data[DATA_W:1];
  assign unused_bits = ^bus.i_gpio_data[GPIO_D-5 -: 3];

  logic valid_s1_reg, valid_s2_reg, valid_hist_reg, strobe_reg;
  logic srst_s1_reg, srst_s2_reg;

  state_t            state_reg, state_next;
  logic [1:0]        kcnt_reg, kcnt_next;
  logic [DATA_W-1:0] kernel_reg [3];
  logic [DATA_W-1:0] kernel_next [3];
  logic              kernel_valid_reg, kernel_valid_next;
  logic [LEN_W-1:0]  img_len_reg, img_len_next;
  logic              wr_en_reg, wr_en_next;
  logic [DATA_W-1:0] wr_data_reg, wr_data_next;
  logic              load_last_reg, load_last_next;
  logic              rd_en_reg, rd_en_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic [RES_W-1:0]  result_reg, result_next;

  // Valid and soft reset synchronizers keep running through soft reset so a
  // valid held across it does not produce a second strobe.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      valid_s1_reg   <= 1'b0;
      valid_s2_reg   <= 1'b0;
      valid_hist_reg <= 1'b0;
      srst_s1_reg    <= 1'b0;
      srst_s2_reg    <= 1'b0;
    end else begin
      valid_s1_reg   <= bus.i_gpio_data[GPIO_D-4];
      valid_s2_reg   <= valid_s1_reg;
      valid_hist_reg <= valid_s2_reg;
      srst_s1_reg    <= bus.i_gpio_data[0];
      srst_s2_reg    <= srst_s1_reg;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset || srst_s2_reg) begin
      state_reg        <= IDLE;
      kcnt_reg         <= '0;
      for (int k = 0; k < 3; k++) kernel_reg[k] <= '0;
      kernel_valid_reg <= 1'b0;
      img_len_reg      <= '0;
      wr_en_reg        <= 1'b0;
      wr_data_reg      <= '0;
      load_last_reg    <= 1'b0;
      rd_en_reg        <= 1'b0;
      busy_reg         <= 1'b0;
      done_reg         <= 1'b0;
      result_reg       <= '0;
      strobe_reg       <= 1'b0;
    end else begin
      state_reg        <= state_next;
      kcnt_reg         <= kcnt_next;
      for (int k = 0; k < 3; k++) kernel_reg[k] <= kernel_next[k];
      kernel_valid_reg <= kernel_valid_next;
      img_len_reg      <= img_len_next;
      wr_en_reg        <= wr_en_next;
      wr_data_reg      <= wr_data_next;
      load_last_reg    <= load_last_next;
      rd_en_reg        <= rd_en_next;
      busy_reg         <= busy_next;
      done_reg         <= done_next;
      result_reg       <= result_next;
      strobe_reg       <= valid_s2_reg & ~valid_hist_reg;
    end
  end

  always_comb begin
    state_next        = state_reg;
    kcnt_next         = kcnt_reg;
    for (int k = 0; k < 3; k++) kernel_next[k] = kernel_reg[k];
    kernel_valid_next = kernel_valid_reg;
    img_len_next      = img_len_reg;
    wr_en_next        = 1'b0;
    wr_data_next      = wr_data_reg;
    load_last_next    = 1'b0;
    rd_en_next        = 1'b0;
    busy_next         = busy_reg;
    done_next         = done_reg;
    // The result popped on the previous cycle is captured here.
    result_next       = rd_en_reg ? bus.i_rd_data : result_reg;

    if (strobe_reg && cmd_ctrl != CMD_KERNEL) kcnt_next = '0;

    if (state_reg == CONV) begin
      // Strobes are dropped in CONV; completion triggers the prefetch pop.
      if (bus.i_conv_done) begin
        state_next = READ;
        done_next  = 1'b1;
        busy_next  = 1'b0;
        rd_en_next = 1'b1;
      end
    end else if (strobe_reg) begin
      case (cmd_ctrl)
        CMD_KERNEL: if (state_reg == IDLE) begin
          for (int k = 0; k < 3; k++)
            if (kcnt_reg == k[1:0]) kernel_next[k] = cmd_data;
          if (kcnt_reg == 2'd2) begin
            kernel_valid_next = 1'b1;
            kcnt_next         = '0;
          end else begin
            if (kcnt_reg == 2'd0) kernel_valid_next = 1'b0;
            kcnt_next = kcnt_reg + 2'd1;
          end
        end
        CMD_LEN: if (state_reg == IDLE) img_len_next = cmd_data[LEN_W-1:0];
        CMD_WRITE: begin
          wr_en_next   = 1'b1;
          wr_data_next = cmd_data;
          done_next    = 1'b0;
          state_next   = LOAD;
        end
        CMD_LAST: begin
          wr_en_next     = 1'b1;
          load_last_next = 1'b1;
          wr_data_next   = cmd_data;
          done_next      = 1'b0;
          busy_next      = 1'b1;
          state_next     = CONV;
        end
        CMD_READ: if (state_reg == READ) rd_en_next = 1'b1;
        default: ;
      endcase
    end
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_kernel_out
    assign bus.o_kernel[gi*DATA_W +: DATA_W] = kernel_reg[gi];
  end

  assign bus.o_gpio_data    = {busy_reg, done_reg, {(GPIO_D-2-RES_W){1'b0}}, result_reg};
  assign bus.o_kernel_valid = kernel_valid_reg;
  assign bus.o_img_len      = img_len_reg;
  assign bus.o_wr_en        = wr_en_reg;
  assign bus.o_wr_data      = wr_data_reg;
  assign bus.o_load_last    = load_last_reg;
  assign bus.o_rd_en        = rd_en_reg;
  assign bus.o_led          = done_reg;
endmodule

// File: tb/tb_gpio_cmd_rx.sv
// Directed bench for gpio_cmd_rx: drives processor GPIO words and a show-ahead
// result queue, checking outputs against hand-computed values.
module tb_gpio_cmd_rx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gpio_cmd_rx_if gif ();
  gpio_cmd_rx dut (.i_clock(clk), .i_reset(rst), .bus(gif.slave));

  int tests = 0;
  int fails = 0;

  // Show-ahead result source: head is visible, o_rd_en pops it.
  logic [12:0] rd_vals [0:31];
  int rd_ptr = 0;
  assign gif.i_rd_data = rd_vals[rd_ptr];

  int wr_cnt = 0, last_cnt = 0, lone_last = 0, rd_cnt = 0;
  always @(posedge clk) begin
    if (gif.o_wr_en) wr_cnt <= wr_cnt + 1;
    if (gif.o_load_last) last_cnt <= last_cnt + 1;
    if (gif.o_load_last && !gif.o_wr_en) lone_last <= lone_last + 1;
    if (gif.o_rd_en) begin
      rd_cnt <= rd_cnt + 1;
      rd_ptr <= rd_ptr + 1;
    end
  end

  function automatic logic [31:0] mk(input logic [2:0] c, input logic v,
                                     input logic [23:0] d, input logic s);
    return {c, v, 3'b000, d, s};
  endfunction

  task automatic raise(input logic [2:0] c, input logic [23:0] d);
    @(negedge clk);
    gif.i_gpio_data = mk(c, 1'b1, d, 1'b0);
  endtask

  task automatic drop();
    @(negedge clk);
    gif.i_gpio_data[28] = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cmd(input logic [2:0] c, input logic [23:0] d);
    raise(c, d);
    repeat (2) @(negedge clk);
    drop();
  endtask

  task automatic test_reset();
    cmd(3'b010, 24'h123456);
    tests++;
    if (gif.o_wr_data !== 24'h123456) begin
      fails++; $display("FAIL reset_pre_wr_data: got %h want 123456", gif.o_wr_data);
    end
    @(posedge clk); #3 rst = 1'b1;
    #1;
    tests++;
    if (gif.o_wr_data !== 24'h0) begin
      fails++; $display("FAIL reset_async: wr_data %h want 0", gif.o_wr_data);
    end
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    tests++;
    if (gif.o_gpio_data !== 32'h0 || gif.o_kernel !== 72'h0 || gif.o_kernel_valid !== 1'b0 ||
        gif.o_img_len !== 11'h0 || gif.o_wr_en !== 1'b0 || gif.o_load_last !== 1'b0 ||
        gif.o_rd_en !== 1'b0 || gif.o_led !== 1'b0) begin
      fails++; $display("FAIL reset_outputs: gpio %h kernel %h kv %b len %h want all 0",
                        gif.o_gpio_data, gif.o_kernel, gif.o_kernel_valid, gif.o_img_len);
    end
    cmd(3'b001, 24'h000007);
    tests++;
    if (gif.o_img_len !== 11'd7) begin
      fails++; $display("FAIL reset_idle_len: got %0d want 7", gif.o_img_len);
    end
  endtask

  task automatic test_kernel();
    cmd(3'b000, 24'h002000);
    cmd(3'b000, 24'h208020);
    raise(3'b000, 24'h002000);
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (gif.o_kernel_valid !== 1'b0) begin
      fails++; $display("FAIL kernel_valid_early: got %b want 0 at 3 clocks", gif.o_kernel_valid);
    end
    @(posedge clk);
    #1;
    tests++;
    if (gif.o_kernel_valid !== 1'b1) begin
      fails++; $display("FAIL kernel_valid_4clk: got %b want 1", gif.o_kernel_valid);
    end
    tests++;
    if (gif.o_kernel !== 72'h002000_208020_002000) begin
      fails++; $display("FAIL kernel_words: got %h want 002000208020002000", gif.o_kernel);
    end
    drop();
  endtask

  task automatic test_length_load();
    int w0, l0;
    cmd(3'b001, 24'hFFF80F);
    w0 = wr_cnt; l0 = last_cnt;
    for (int i = 0; i < 16; i++) cmd(3'b010, 24'(i + 1));
    cmd(3'b100, 24'hABCDEF);
    tests++;
    if (gif.o_img_len !== 11'd15) begin
      fails++; $display("FAIL len_value: got %0d want 15", gif.o_img_len);
    end
    tests++;
    if (wr_cnt - w0 !== 17) begin
      fails++; $display("FAIL load_wr_count: got %0d want 17", wr_cnt - w0);
    end
    tests++;
    if (last_cnt - l0 !== 1 || lone_last !== 0) begin
      fails++; $display("FAIL load_last: count %0d lone %0d want 1 and 0", last_cnt - l0, lone_last);
    end
    tests++;
    if (gif.o_wr_data !== 24'hABCDEF || gif.o_gpio_data[31] !== 1'b1) begin
      fails++; $display("FAIL load_busy: wr_data %h busy %b want ABCDEF 1",
                        gif.o_wr_data, gif.o_gpio_data[31]);
    end
  endtask

  task automatic test_conv_ignore();
    int w0;
    w0 = wr_cnt;
    cmd(3'b010, 24'h555555);
    tests++;
    if (wr_cnt !== w0 || gif.o_wr_data !== 24'hABCDEF || gif.o_gpio_data[31] !== 1'b1) begin
      fails++; $display("FAIL conv_ignore: writes %0d data %h busy %b want 0 ABCDEF 1",
                        wr_cnt - w0, gif.o_wr_data, gif.o_gpio_data[31]);
    end
  endtask

  task automatic test_conv_done();
    int r0;
    r0 = rd_cnt;
    @(negedge clk); gif.i_conv_done = 1'b1;
    @(negedge clk); gif.i_conv_done = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (gif.o_led !== 1'b1 || gif.o_gpio_data[31:30] !== 2'b01) begin
      fails++; $display("FAIL done_flags: led %b busy/done %b want 1 01",
                        gif.o_led, gif.o_gpio_data[31:30]);
    end
    tests++;
    if (gif.o_gpio_data[12:0] !== 13'h0ABC || rd_cnt - r0 !== 1) begin
      fails++; $display("FAIL prefetch: result %h pops %0d want 0abc 1",
                        gif.o_gpio_data[12:0], rd_cnt - r0);
    end
  endtask

  task automatic test_readout();
    int r0;
    r0 = rd_cnt;
    for (int i = 1; i <= 26; i++) begin
      raise(3'b011, 24'h0);
      repeat (4) @(posedge clk);
      #1;
      tests++;
      if (gif.o_gpio_data[12:0] !== rd_vals[i-1]) begin
        fails++; $display("FAIL readout_early[%0d]: got %h want %h", i, gif.o_gpio_data[12:0], rd_vals[i-1]);
      end
      @(posedge clk);
      #1;
      tests++;
      if (gif.o_gpio_data[12:0] !== rd_vals[i]) begin
        fails++; $display("FAIL readout_5clk[%0d]: got %h want %h", i, gif.o_gpio_data[12:0], rd_vals[i]);
      end
      drop();
    end
    tests++;
    if (rd_cnt - r0 !== 26) begin
      fails++; $display("FAIL readout_pops: got %0d want 26", rd_cnt - r0);
    end
  endtask

  task automatic test_held_valid();
    int r0;
    r0 = rd_cnt;
    raise(3'b011, 24'h0);
    repeat (20) @(negedge clk);
    drop();
    tests++;
    if (rd_cnt - r0 !== 1 || gif.o_gpio_data[12:0] !== rd_vals[27]) begin
      fails++; $display("FAIL held_valid: pops %0d result %h want 1 %h",
                        rd_cnt - r0, gif.o_gpio_data[12:0], rd_vals[27]);
    end
  endtask

  task automatic test_illegal();
    int w0, l0, r0;
    logic [31:0] g0;
    w0 = wr_cnt; l0 = last_cnt; r0 = rd_cnt; g0 = gif.o_gpio_data;
    cmd(3'b111, 24'hFFFFFF);
    tests++;
    if (wr_cnt !== w0 || last_cnt !== l0 || rd_cnt !== r0 || gif.o_gpio_data !== g0 ||
        gif.o_img_len !== 11'd15) begin
      fails++; $display("FAIL illegal_ctrl: wr %0d last %0d rd %0d gpio %h want no change from %h",
                        wr_cnt - w0, last_cnt - l0, rd_cnt - r0, gif.o_gpio_data, g0);
    end
  endtask

  task automatic test_soft_reset();
    @(negedge clk); gif.i_gpio_data = mk(3'b000, 1'b0, 24'h0, 1'b1);
    repeat (4) @(negedge clk);
    gif.i_gpio_data = 32'h0;
    repeat (2) @(negedge clk);
    tests++;
    if (gif.o_led !== 1'b0 || gif.o_gpio_data !== 32'h0 || gif.o_kernel !== 72'h0 ||
        gif.o_kernel_valid !== 1'b0 || gif.o_img_len !== 11'h0) begin
      fails++; $display("FAIL soft_reset: led %b gpio %h kernel %h kv %b len %h want all 0",
                        gif.o_led, gif.o_gpio_data, gif.o_kernel, gif.o_kernel_valid, gif.o_img_len);
    end
    cmd(3'b001, 24'h000009);
    tests++;
    if (gif.o_img_len !== 11'd9) begin
      fails++; $display("FAIL soft_reset_idle: len %0d want 9", gif.o_img_len);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got hang want completion");
    $fatal(1, "timeout");
  end

  initial begin
    rd_vals[0] = 13'h0ABC;
    for (int i = 1; i < 32; i++) rd_vals[i] = 13'h100 + 13'(i);
    gif.i_gpio_data = 32'h0;
    gif.i_conv_done = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_kernel();
    test_length_load();
    test_conv_ignore();
    test_conv_done();
    test_readout();
    test_held_valid();
    test_illegal();
    test_soft_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/gpio_cmd_rx.md
Name: gpio_cmd_rx

Overview:
- FPGA-side responder for the 32-bit processor GPIO command protocol.
- Decodes the processor output word {ctrl[2:0], valid, 3'b0, data[23:0], soft_rst}, edge-detects the asynchronous valid strobe and dispatches commands: kernel load, image length, image data write, last-write, result readout.
- Returns convolution results and a done flag on the GPIO input word.
- Sits between the GPIO bridge and the memory/convolution datapath.

Parameters:
- GPIO_D, 32, GPIO word width.
- DATA_W, 24, payload width.
- RES_W, 13, convolution result width.
- LEN_W, 11, image length register width.

Ports:
- i_clock  in  1  system clock.
- i_reset  in  1  asynchronous active-high reset.
- i_gpio_data  in  GPIO_D  processor output word: [31:29] ctrl, [28] valid, [27:25] unused, [24:1] data, [0] soft reset.
- o_gpio_data  out  GPIO_D  word to processor: [31] busy, [30] done, [29:13] zero, [12:0] result.
- o_kernel  out  3*DATA_W  kernel words; word k occupies [24k+23:24k].
- o_kernel_valid  out  1  all three kernel words loaded.
- o_img_len  out  LEN_W  image length.
- o_wr_en  out  1  one-cycle image write strobe.
- o_wr_data  out  DATA_W  image write data.
- o_load_last  out  1  one-cycle pulse with the final write; starts convolution.
- i_conv_done  in  1  one-cycle pulse from the datapath.
- o_rd_en  out  1  one-cycle result pop request.
- i_rd_data  in  RES_W  result, valid the cycle after o_rd_en.
- o_led  out  1  mirrors the done bit.

Behaviour:
- Clock and reset:
  - i_reset is asynchronous: all outputs and registers go to 0, and the FSM goes to IDLE.
  - Soft reset is bit 0 through a 2-flop synchronizer. While it is high it synchronously applies the same clear.
- Valid handling:
  - Bit 28 passes through a 2-flop synchronizer plus a history flop; strobe = sync & ~hist.
  - ctrl and data are sampled directly on the strobe cycle. The processor holds them stable at least 100 ns before raising valid.
  - Strobe-to-output latency is 4 clocks from the valid rising edge at the input pin: 3 synchronizer/edge-detect clocks plus 1 registered output.
  - A falling valid does nothing. A held-high valid produces exactly one strobe.
- FSM states: IDLE, LOAD, CONV, READ.
- ctrl 000 (kernel), IDLE only:
  - Stores data into slot kcnt; kcnt increments 0, 1, 2.
  - After slot 2, o_kernel_valid=1 and kcnt wraps to 0.
  - A strobe at kcnt=0 clears o_kernel_valid.
  - Any non-000 strobe resets kcnt to 0.
- ctrl 001 (length), IDLE only: o_img_len <= data[LEN_W-1:0]. Excess upper bits are ignored.
- ctrl 010 (write), IDLE or LOAD: o_wr_en pulse with o_wr_data=data; go to LOAD. A write clears done.
- ctrl 100 (last), IDLE or LOAD: o_wr_en and o_load_last pulse together; go to CONV; busy=1.
- CONV:
  - Strobes are ignored.
  - i_conv_done sets done=1, clears busy and goes to READ.
  - While entering READ, one prefetch o_rd_en is issued. The next cycle's i_rd_data is latched into o_gpio_data[12:0], so the first result is visible before any readout strobe.
- ctrl 011 (readout), READ only: each strobe issues o_rd_en. i_rd_data is latched one cycle later, so the total is 5 clocks from the valid edge.
- Leaving READ:
  - A 010 or 100 strobe in READ acts as in IDLE (begins a new band).
  - Done clears on that write.
  - The result register holds its last value.
- Ignored inputs:
  - Illegal ctrl codes (101, 110, 111) and commands not legal in the current state are ignored, with no outputs.
  - i_conv_done outside CONV is ignored.
- Priority when an i_conv_done pulse and a strobe land in the same cycle in CONV: conv_done is taken and the strobe is dropped.
- Width rules: o_wr_data is the full 24 bits. The result is zero-extended into the 32-bit word.

Test Plan:
- Async reset mid-LOAD: i_reset high 3 cycles -> all outputs 0, state IDLE, o_kernel=0.
- Kernel load: strobes with data 24'h002000, 24'h208020, 24'h002000 under ctrl 000 -> o_kernel=72'h002000_208020_002000, o_kernel_valid=1 exactly 4 clocks after the third valid edge.
- Length plus load: ctrl 001 data 15, then sixteen 010 strobes, then one 100 strobe -> o_img_len=15, seventeen o_wr_en pulses, one o_load_last coincident with the last write, busy=1.
- Done and prefetch: pulse i_conv_done with i_rd_data=13'h0ABC -> o_led=1, busy=0, o_gpio_data[12:0]=0ABC with no valid strobe.
- Readout: 26 ctrl 011 strobes feeding incrementing i_rd_data -> 26 o_rd_en pulses, each value visible 5 clocks after its valid edge. Valid held high 20 cycles -> single o_rd_en.
- Edge cases:
  - Soft reset bit asserted in READ -> IDLE with done=0.
  - ctrl 111 strobe -> no output activity.
  - ctrl 010 strobe during CONV -> no o_wr_en.
